// File: rtl/pong_title_render_if.sv
// Pixel-side and bitmap-ROM-side signals of the PONG title renderer.
interface pong_title_render_if;
    logic [9:0]   pixel_x;
    logic [9:0]   pixel_y;
    logic         video_on;
    logic         refresh_tick;
    logic         enable;
    logic [4:0]   drom_addr_num;
    logic [0:127] drom_data_num;
    logic         title_on;
    logic [11:0]  title_rgb;

    modport slave (
        input  pixel_x, pixel_y, video_on, refresh_tick, enable, drom_data_num,
        output drom_addr_num, title_on, title_rgb
    );

    modport master (
        output pixel_x, pixel_y, video_on, refresh_tick, enable, drom_data_num,
        input  drom_addr_num, title_on, title_rgb
    );
endinterface

// File: rtl/pong_title_render.sv
// PONG title bitmap reader: 2-stage pixel pipeline plus frame-counted blink/palette FSM.
// state | meaning :  SHOW | title drawn   HIDE | title blanked
module pong_title_render #(
    parameter int X0           = 192,
    parameter int Y0           = 160,
    parameter int SCALE_LOG2   = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              reset,
    pong_title_render_if.slave bus
);
    localparam int W  = 128 << SCALE_LOG2;
    localparam int H  = 32 << SCALE_LOG2;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]   X_LO = 11'(X0);
    localparam logic [10:0]   X_HI = 11'(X0 + W);
    localparam logic [10:0]   Y_LO = 11'(Y0);
    localparam logic [10:0]   Y_HI = 11'(Y0 + H);
    localparam logic [CW-1:0] FRAME_TC = CW'(BLINK_FRAMES - 1);

    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [1:0]    r_color_idx, w_color_idx_nxt;

    logic [10:0] w_px, w_py;
    logic        w_in_box;
    logic [4:0]  w_row;
    logic [6:0]  w_col;
    logic        r_hit_q;
    logic [6:0]  r_col_q;
    logic        w_lit;
    logic [11:0] w_palette;

    // 11-bit compare keeps X0+W from wrapping against the 10-bit pixel counters
    assign w_px     = {1'b0, bus.pixel_x};
    assign w_py     = {1'b0, bus.pixel_y};
    assign w_in_box = (w_px >= X_LO) && (w_px < X_HI) && (w_py >= Y_LO) && (w_py < Y_HI);
    assign w_row    = 5'((w_py - Y_LO) >> SCALE_LOG2);
    assign w_col    = 7'((w_px - X_LO) >> SCALE_LOG2);

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.drom_addr_num <= '0;
            r_col_q           <= '0;
            r_hit_q           <= 1'b0;
        end else begin
            bus.drom_addr_num <= w_row;
            r_col_q           <= w_col;
            r_hit_q           <= w_in_box & bus.video_on;
        end
    end

    always_comb begin
        w_palette = 12'hFFF;
        case (r_color_idx)
            2'd0: w_palette = 12'hFFF;
            2'd1: w_palette = 12'hF00;
            2'd2: w_palette = 12'h0F0;
            2'd3: w_palette = 12'h00F;
            default: w_palette = 12'hFFF;
        endcase
    end

    // enable is used unregistered so the title blanks at the first edge it is seen low
    assign w_lit = r_hit_q & bus.drom_data_num[r_col_q] & (r_state == SHOW) & bus.enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.title_on  <= 1'b0;
            bus.title_rgb <= '0;
        end else begin
            bus.title_on  <= w_lit;
            bus.title_rgb <= w_lit ? w_palette : 12'h000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SHOW;
            r_frame_cnt <= '0;
            r_color_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_color_idx <= w_color_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_color_idx_nxt = r_color_idx;
        if (!bus.enable) begin
            w_state_nxt     = SHOW;
            w_frame_cnt_nxt = '0;
            w_color_idx_nxt = '0;
        end else if (bus.refresh_tick) begin
            if (r_frame_cnt == FRAME_TC) begin
                w_frame_cnt_nxt = '0;
                case (r_state)
                    SHOW: w_state_nxt = HIDE;
                    HIDE: begin
                        w_state_nxt     = SHOW;
                        w_color_idx_nxt = r_color_idx + 2'd1;
                    end
                    default: w_state_nxt = SHOW;
                endcase
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_pong_title_render.sv
// Directed bench for pong_title_render: pipeline, box edges, gating, blink/palette, windowed sweep at three scales.
module tb_pong_title_render;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [11:0] pal [4] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F};

    always #5 clk = ~clk;

    pong_title_render_if bus0 ();
    pong_title_render_if bus1 ();
    pong_title_render_if bus2 ();

    pong_title_render #(.SCALE_LOG2(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pong_title_render #(.SCALE_LOG2(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pong_title_render #(.SCALE_LOG2(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    function automatic logic rom_bit(input int r, input int c);
        return ((((r ^ c) & 3) == 3) ? 1'b1 : 1'b0) ^ (((c >> 4) == (r & 7)) ? 1'b1 : 1'b0);
    endfunction

    function automatic logic [0:127] rom_row(input logic [4:0] r);
        logic [0:127] v;
        for (int c = 0; c < 128; c++) v[c] = rom_bit(int'(r), c);
        return v;
    endfunction

    always_comb bus0.drom_data_num = rom_row(bus0.drom_addr_num);
    always_comb bus1.drom_data_num = rom_row(bus1.drom_addr_num);
    always_comb bus2.drom_data_num = rom_row(bus2.drom_addr_num);

    function automatic logic exp_on(input int x, input int y, input logic vo, input int s);
        if (vo && x >= 192 && x < 192 + (128 << s) && y >= 160 && y < 160 + (32 << s))
            return rom_bit((y - 160) >> s, (x - 192) >> s);
        return 1'b0;
    endfunction

    task automatic drive(input int x, input int y, input logic vo, input logic tk, input logic en);
        bus0.pixel_x = 10'(x); bus0.pixel_y = 10'(y); bus0.video_on = vo; bus0.refresh_tick = tk; bus0.enable = en;
        bus1.pixel_x = 10'(x); bus1.pixel_y = 10'(y); bus1.video_on = vo; bus1.refresh_tick = tk; bus1.enable = en;
        bus2.pixel_x = 10'(x); bus2.pixel_y = 10'(y); bus2.video_on = vo; bus2.refresh_tick = tk; bus2.enable = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // applies one pixel, returns the row address seen one edge later; title outputs are valid on return
    task automatic pixel_pipe(input int x, input int y, input logic vo, input logic en, output logic [4:0] addr);
        drive(x, y, vo, 1'b0, en);
        step();
        addr = bus1.drom_addr_num;
        step();
    endtask

    task automatic tick_pulse();
        drive(194, 188, 1'b1, 1'b1, 1'b1);
        step();
        drive(194, 188, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom), 1'($urandom), 1'b1);
            step();
            total++;
            if (bus1.title_on !== 1'b0 || bus1.title_rgb !== 12'h000 || bus1.drom_addr_num !== 5'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: on=%b rgb=%h addr=%0d, want 0/000/0", i, bus1.title_on, bus1.title_rgb, bus1.drom_addr_num);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lit_pixel();
        logic [4:0] a;
        pixel_pipe(194, 188, 1'b1, 1'b1, a);
        total++;
        if (a !== 5'd14) begin bad++; $display("FAIL lit_addr got %0d want 14", a); end
        total++;
        if (bus1.title_on !== 1'b1 || bus1.title_rgb !== 12'hFFF) begin
            bad++; $display("FAIL lit_pixel got on=%b rgb=%h want 1/fff", bus1.title_on, bus1.title_rgb);
        end
        pixel_pipe(192, 188, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b0 || bus1.title_rgb !== 12'h000) begin
            bad++; $display("FAIL dark_pixel got on=%b rgb=%h want 0/000", bus1.title_on, bus1.title_rgb);
        end
    endtask

    task automatic test_box_edges();
        int   xs [9] = '{447, 448, 194, 191, 447, 448, 192, 192, 192};
        int   ys [9] = '{188, 188, 224, 188, 184, 184, 223, 224, 160};
        logic ex [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] a;
        for (int i = 0; i < 9; i++) begin
            pixel_pipe(xs[i], ys[i], 1'b1, 1'b1, a);
            total++;
            if (bus1.title_on !== ex[i]) begin
                bad++; $display("FAIL box_edge (%0d,%0d) got on=%b want %b", xs[i], ys[i], bus1.title_on, ex[i]);
            end
        end
        pixel_pipe(447, 188, 1'b1, 1'b1, a);
        total++;
        if (a !== 5'd14) begin bad++; $display("FAIL edge_addr got %0d want 14", a); end
        pixel_pipe(191, 160, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b0) begin bad++; $display("FAIL box_left_of_corner got %b want 0", bus1.title_on); end
        pixel_pipe(192, 159, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b0) begin bad++; $display("FAIL box_above_corner got %b want 0", bus1.title_on); end
    endtask

    task automatic test_gating();
        logic [4:0] a;
        pixel_pipe(194, 188, 1'b0, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b0 || bus1.title_rgb !== 12'h000) begin
            bad++; $display("FAIL video_off got on=%b rgb=%h want 0/000", bus1.title_on, bus1.title_rgb);
        end
        pixel_pipe(194, 188, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b1) begin bad++; $display("FAIL gate_prelit got %b want 1", bus1.title_on); end
        drive(194, 188, 1'b1, 1'b0, 1'b0);
        step();
        total++;
        if (bus1.title_on !== 1'b0 || bus1.title_rgb !== 12'h000) begin
            bad++; $display("FAIL enable_drop got on=%b rgb=%h want 0/000", bus1.title_on, bus1.title_rgb);
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] a;
        pixel_pipe(194, 188, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b1) begin bad++; $display("FAIL mid_reset_pre got %b want 1", bus1.title_on); end
        reset = 1'b1;
        step();
        total++;
        if (bus1.title_on !== 1'b0 || bus1.drom_addr_num !== 5'd0) begin
            bad++; $display("FAIL mid_reset_edge got on=%b addr=%0d want 0/0", bus1.title_on, bus1.drom_addr_num);
        end
        reset = 1'b0;
        step();
        total++;
        if (bus1.title_on !== 1'b0) begin bad++; $display("FAIL mid_reset_inflight got %b want 0", bus1.title_on); end
        step();
        total++;
        if (bus1.title_on !== 1'b1) begin bad++; $display("FAIL mid_reset_resume got %b want 1", bus1.title_on); end
    endtask

    task automatic test_blink_palette();
        logic [4:0] a;
        logic       vis;
        logic [11:0] rgb;
        do_reset();
        for (int f = 0; f <= 240; f++) begin
            pixel_pipe(194, 188, 1'b1, 1'b1, a);
            vis = ((f / 30) % 2) == 0;
            rgb = vis ? pal[(f / 60) % 4] : 12'h000;
            total++;
            if (bus1.title_on !== vis || bus1.title_rgb !== rgb) begin
                bad++; $display("FAIL blink frame %0d got on=%b rgb=%h want %b/%h", f, bus1.title_on, bus1.title_rgb, vis, rgb);
            end
            if (f < 240) tick_pulse();
        end
    endtask

    task automatic test_enable_clear();
        logic [4:0] a;
        do_reset();
        for (int k = 0; k < 60; k++) tick_pulse();
        pixel_pipe(194, 188, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b1 || bus1.title_rgb !== 12'hF00) begin
            bad++; $display("FAIL clear_pre got on=%b rgb=%h want 1/f00", bus1.title_on, bus1.title_rgb);
        end
        drive(194, 188, 1'b1, 1'b1, 1'b0);
        step();
        total++;
        if (bus1.title_on !== 1'b0) begin bad++; $display("FAIL clear_tick_edge got %b want 0", bus1.title_on); end
        pixel_pipe(194, 188, 1'b1, 1'b1, a);
        total++;
        if (bus1.title_on !== 1'b1 || bus1.title_rgb !== 12'hFFF) begin
            bad++; $display("FAIL clear_restart got on=%b rgb=%h want 1/fff", bus1.title_on, bus1.title_rgb);
        end
        for (int k = 1; k <= 30; k++) begin
            tick_pulse();
            step();
            step();
            total++;
            if (bus1.title_on !== (k < 30)) begin
                bad++; $display("FAIL clear_count tick %0d got %b want %b", k, bus1.title_on, (k < 30));
            end
        end
    endtask

    task automatic test_stream();
        logic e1 [3];
        logic e2 [3];
        logic on_v [3];
        logic [11:0] rgb_v [3];
        logic vo;
        do_reset();
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        for (int s = 0; s < 3; s++) begin e1[s] = 1'b0; e2[s] = 1'b0; end
        for (int y = 156; y <= 293; y++) begin
            for (int x = 184; x < 640; x++) begin
                step();
                on_v[0] = bus0.title_on; on_v[1] = bus1.title_on; on_v[2] = bus2.title_on;
                rgb_v[0] = bus0.title_rgb; rgb_v[1] = bus1.title_rgb; rgb_v[2] = bus2.title_rgb;
                for (int s = 0; s < 3; s++) begin
                    total++;
                    if (on_v[s] !== e2[s] || rgb_v[s] !== (e2[s] ? 12'hFFF : 12'h000)) begin
                        bad++;
                        if (bad < 20)
                            $display("FAIL stream scale%0d near (%0d,%0d) got on=%b rgb=%h want %b", s, x, y, on_v[s], rgb_v[s], e2[s]);
                    end
                    e2[s] = e1[s];
                end
                vo = (x < 636) && (y < 292);
                for (int s = 0; s < 3; s++) e1[s] = exp_on(x, y, vo, s);
                drive(x, y, vo, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_lit_pixel();
        test_box_edges();
        test_gating();
        test_mid_reset();
        test_blink_palette();
        test_enable_clear();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
